// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising receive checker for an 8-bit XNOR LFSR stream (taps 7,3).
// Optional bit_cnt output for BER measurement when LFSR_CHK_BITCNT_EN is defined.
module lfsr_checker #(
  parameter int LOCK_GOOD   = 8,
  parameter int LOSS_THRESH = 4,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear,
  output logic             locked,
  output logic             bit_err,
`ifdef LFSR_CHK_BITCNT_EN
  output logic [ERR_W+7:0] bit_cnt,
`endif
  output logic [ERR_W-1:0] err_cnt
);
  typedef enum logic [1:0] {SEED, ACQ, LOCKED} state_t;
  state_t state_q, state_d;
  logic [7:0] hist_q, good_q, good_d, bad_q, bad_d, good_inc, bad_inc;
  logic [2:0] fill_q;
  logic [ERR_W-1:0] err_q, err_d;
  logic locked_q, bit_err_q, match, miss, cmp;
  assign match    = in_bit == ~(hist_q[7] ^ hist_q[3]);
  assign cmp      = in_valid && state_q == LOCKED;
  assign miss     = cmp && !match;
  assign good_inc = good_q + 8'd1;
  assign bad_inc  = bad_q + 8'd1;
  assign err_d    = clear ? '0 : (miss && !(&err_q)) ? err_q + 1'b1 : err_q;
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    if (in_valid)
      case (state_q)
        SEED: if (fill_q == 3'd7) begin
          state_d = ACQ;
          good_d  = '0;
        end
        ACQ: if (!match) good_d = '0;
        else if (good_inc == 8'(LOCK_GOOD)) begin
          state_d = LOCKED;
          good_d  = '0;
          bad_d   = '0;
        end else good_d = good_inc;
        LOCKED: if (!match) begin
          good_d  = '0;
          bad_d   = bad_inc;
          state_d = bad_inc == 8'(LOSS_THRESH) ? ACQ : LOCKED;
        end else if (good_inc == 8'(LOCK_GOOD)) begin
          good_d = '0;
          bad_d  = '0;
        end else good_d = good_inc;
        default: state_d = SEED;
      endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= SEED;
      hist_q    <= '0;
      fill_q    <= '0;
      good_q    <= '0;
      bad_q     <= '0;
      locked_q  <= 1'b0;
      bit_err_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      locked_q  <= state_d == LOCKED;
      bit_err_q <= miss;
      err_q     <= err_d;
      if (in_valid) hist_q <= {hist_q[6:0], in_bit};
      if (in_valid && state_q == SEED) fill_q <= fill_q + 3'd1;
    end
`ifdef LFSR_CHK_BITCNT_EN
  logic [ERR_W+7:0] bcnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) bcnt_q <= '0;
    else bcnt_q <= clear ? '0 : (cmp && !(&bcnt_q)) ? bcnt_q + 1'b1 : bcnt_q;
  assign bit_cnt = bcnt_q;
`endif
  assign locked  = locked_q;
  assign bit_err = bit_err_q;
  assign err_cnt = err_q;
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: vector table, directed corner sequences and randomized traffic against a queue-based model.
module tb_lfsr_checker;
  localparam int LG = 8, LT = 4, EW = 8;
  logic clk = 0, reset = 1, in_valid = 0, in_bit = 0, clear = 0;
  logic locked, bit_err;
  logic [EW-1:0] err_cnt;
`ifdef LFSR_CHK_BITCNT_EN
  logic [EW+7:0] bit_cnt;
`endif
  lfsr_checker #(.LOCK_GOOD(LG), .LOSS_THRESH(LT), .ERR_W(EW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
    .locked(locked), .bit_err(bit_err),
`ifdef LFSR_CHK_BITCNT_EN
    .bit_cnt(bit_cnt),
`endif
    .err_cnt(err_cnt));
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  logic [7:0] g = 8'h00;
  bit m_q[$];
  int m_run, m_miss, m_err;
  bit m_lock, m_berr;
  longint m_bits;
  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic m_reset();
    m_q.delete();
    m_run = 0; m_miss = 0; m_err = 0; m_lock = 0; m_berr = 0; m_bits = 0;
  endtask
  // Prediction uses the bits received 8 and 4 valid bits earlier.
  task automatic model(input bit v, input bit b, input bit c);
    bit ok;
    m_berr = 0;
    if (v) begin
      if (m_q.size() == 8) begin
        ok = b == ~(m_q[0] ^ m_q[4]);
        if (!m_lock) begin
          m_run = ok ? m_run + 1 : 0;
          if (m_run == LG) begin m_lock = 1; m_run = 0; m_miss = 0; end
        end else begin
          m_bits++;
          if (!ok) begin
            m_berr = 1; m_run = 0; m_miss++;
            if (m_err < (1 << EW) - 1) m_err++;
            if (m_miss == LT) m_lock = 0;
          end else begin
            m_run++;
            if (m_run == LG) begin m_run = 0; m_miss = 0; end
          end
        end
        void'(m_q.pop_front());
      end
      m_q.push_back(b);
    end
    if (c) begin m_err = 0; m_bits = 0; end
  endtask
  task automatic gbit(output bit b);
    b = ~(g[7] ^ g[3]);
    g = {g[6:0], b};
  endtask
  task automatic cyc(input bit v, input bit b, input bit c);
    in_valid = v; in_bit = b; clear = c;
    @(posedge clk);
    model(v, b, c);
    @(negedge clk);
    chk("locked", locked, m_lock);
    chk("bit_err", bit_err, m_berr);
    chk("err_cnt", err_cnt, m_err);
`ifdef LFSR_CHK_BITCNT_EN
    chk("bit_cnt", bit_cnt, m_bits);
`endif
  endtask
  task automatic send(input int n, input bit inv);
    bit b;
    repeat (n) begin gbit(b); cyc(1, b ^ inv, 0); end
  endtask
  task automatic async_reset();
    #2 reset = 1;
    m_reset();
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_bit_err", bit_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(negedge clk) reset = 0;
  endtask
  typedef struct {bit v; bit b; bit lk; bit be; int err;} vec_t;
  vec_t tbl[16];
  initial begin
    bit b, v, f, c;
    int vcnt;
    logic [15:0] seq = 16'b1111_0000_0000_1111;
    for (int i = 0; i < 16; i++) tbl[i] = '{1, seq[15-i], i == 15, 0, 0};
    m_reset();
    @(negedge clk);
    chk("reset_locked", locked, 0);
    chk("reset_bit_err", bit_err, 0);
    chk("reset_err_cnt", err_cnt, 0);
    reset = 0;
    for (int i = 0; i < 16; i++) begin
      gbit(b);
      cyc(tbl[i].v, tbl[i].b, 0);
      chk("tbl_locked", locked, tbl[i].lk);
      chk("tbl_bit_err", bit_err, tbl[i].be);
      chk("tbl_err_cnt", err_cnt, tbl[i].err);
    end
    send(200, 0);
    chk("clean_err", err_cnt, 0);
    chk("clean_locked", locked, 1);
    for (int i = 0; i < 12; i++) begin
      gbit(b);
      cyc(1, b ^ (i == 0), 0);
      chk("flip_pulse", bit_err, i == 0 || i == 4 || i == 8);
    end
    chk("flip_err", err_cnt, 3);
    chk("flip_locked", locked, 1);
    gbit(b); cyc(1, b, 1);
    chk("clear_err", err_cnt, 0);
    send(12, 0);
    for (int k = 0; k < 4; k++) begin send(1, 1); send(19, 0); end
    chk("spaced_err", err_cnt, 12);
    chk("spaced_locked", locked, 1);
    for (int i = 0; i < 4; i++) begin
      send(1, 1);
      chk("burst_locked", locked, i < 3);
    end
    chk("burst_err", err_cnt, 16);
    send(15, 0);
    chk("relock_early", locked, 0);
    send(1, 0);
    chk("relock", locked, 1);
    chk("relock_err", err_cnt, 16);
    send(1, 1);
    chk("pre_rst_bit_err", bit_err, 1);
    async_reset();
    send(15, 0);
    chk("rst_relock_early", locked, 0);
    send(1, 0);
    chk("rst_relock", locked, 1);
    async_reset();
    vcnt = 0;
    for (int i = 0; i < 32; i++) begin
      v = i % 2 == 0;
      if (v) begin gbit(b); vcnt++; end else b = 1'($urandom);
      cyc(v, b, 0);
      chk("alt_locked", locked, vcnt >= 16);
      chk("alt_bit_err", bit_err, 0);
    end
    gbit(b); cyc(1, b, 1);
    repeat (63) begin send(4, 1); send(16, 0); end
    chk("sat_252", err_cnt, 252);
    send(2, 1);
    chk("sat_fe", err_cnt, 8'hFE);
    send(24, 0);
    chk("sat_ff", err_cnt, 8'hFF);
    chk("sat_locked", locked, 1);
    send(4, 1); send(16, 0);
    chk("sat_hold", err_cnt, 8'hFF);
    gbit(b); cyc(1, ~b, 1);
    chk("clr_miss_err", err_cnt, 0);
    chk("clr_miss_pulse", bit_err, 1);
    send(30, 0);
    repeat (3000) begin
      v = $urandom_range(0, 3) != 0;
      f = $urandom_range(0, 39) == 0;
      c = $urandom_range(0, 99) == 0;
      if (v) gbit(b); else b = 1'($urandom);
      cyc(v, b ^ f, c);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
